sap_clken_gen: RTL and testbench

- Parametrised successor to the fixed divide-by-CLKLEN clock-enable logic that drives sap1.
- Derives the slow machine clock and its enables from sysclk:
  - clk: a square wave for front-panel display.
  - clken: a one-sysclk pulse at each clk rising edge.
  - clken_oop: a one-sysclk pulse at each clk falling edge.
- Adds a runtime-selectable divider, free-run and single-step modes, halt capture and a machine-cycle counter.
- Sits between the front panel and sap1; sap1's halt output feeds back into this block.

---
 rtl/sap_clken_gen_if.sv | 26 ++
 rtl/sap_clken_gen.sv | 118 +++++++++++
 tb/tb_sap_clken_gen.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/sap_clken_gen_if.sv
// Control and status bundle between the front panel / sap1 and the clock-enable generator.
// The generator sits on the slave side; the front panel drives the master side.
interface sap_clken_gen_if #(
    parameter int DIV_W = 4,
    parameter int CYC_W = 16
);
    logic [DIV_W-1:0] div;
    logic             mode;
    logic             fp_step;
    logic             halt;
    logic             clk;
    logic             clken;
    logic             clken_oop;
    logic             halted;
    logic [CYC_W-1:0] cycle_cnt;

    modport master (
        output div, mode, fp_step, halt,
        input  clk, clken, clken_oop, halted, cycle_cnt
    );

    modport slave (
        input  div, mode, fp_step, halt,
        output clk, clken, clken_oop, halted, cycle_cnt
    );
endinterface

// File: rtl/sap_clken_gen.sv
// Slow machine clock and rise/fall enables for sap1, derived from sysclk with a runtime divider,
// free-run / single-step modes, halt capture and a machine-cycle counter.
module sap_clken_gen #(
    parameter int DIV_W       = 4,
    parameter int DIV_DEFAULT = 4,
    parameter int CYC_W       = 16
) (
    input  logic                 sysclk,
    input  logic                 reset,
    sap_clken_gen_if.slave       bus
);
    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_IDLE   = 2'd1,
        ST_STEP   = 2'd2,
        ST_HALTED = 2'd3
    } state_t;

    localparam logic [DIV_W-1:0] DIV_RST = (DIV_DEFAULT == 0) ? DIV_W'(1) : DIV_W'(DIV_DEFAULT);

    state_t           state_reg, state_next;
    logic [DIV_W-1:0] count_reg, count_next;
    logic [DIV_W-1:0] div_act_reg, div_act_next;
    logic             clk_reg, clk_next;
    logic             clken_reg, clken_next;
    logic             clken_oop_reg, clken_oop_next;
    logic [CYC_W-1:0] cycle_cnt_reg, cycle_cnt_next;
    logic [2:0]       step_sync_reg;

    logic [DIV_W-1:0] div_eff;
    logic             step_p;
    logic             terminal;

    assign div_eff  = (bus.div == '0) ? DIV_W'(1) : bus.div;
    // Bits [1:0] synchronise the button; bit 2 is the previous synchronised level.
    assign step_p   = step_sync_reg[1] & ~step_sync_reg[2];
    assign terminal = (count_reg == (div_act_reg - DIV_W'(1)));

    always_comb begin
        state_next     = state_reg;
        count_next     = count_reg;
        div_act_next   = div_act_reg;
        clk_next       = clk_reg;
        clken_next     = 1'b0;
        clken_oop_next = 1'b0;
        cycle_cnt_next = cycle_cnt_reg;

        case (state_reg)
            ST_RUN, ST_STEP: begin
                if (terminal) begin
                    count_next = '0;
                    if (!clk_reg) begin
                        // Halt is only taken where a rising edge would start the next machine cycle.
                        if (bus.halt) begin
                            state_next = ST_HALTED;
                        end else begin
                            clk_next       = 1'b1;
                            clken_next     = 1'b1;
                            cycle_cnt_next = cycle_cnt_reg + CYC_W'(1);
                        end
                    end else begin
                        clk_next       = 1'b0;
                        clken_oop_next = 1'b1;
                        div_act_next   = div_eff;
                        if (state_reg == ST_STEP || bus.mode) begin
                            state_next = ST_IDLE;
                        end
                    end
                end else begin
                    count_next = count_reg + DIV_W'(1);
                end
            end
            ST_IDLE: begin
                count_next   = '0;
                clk_next     = 1'b0;
                div_act_next = div_eff;
                if (!bus.mode) begin
                    state_next = ST_RUN;
                end else if (step_p) begin
                    state_next = ST_STEP;
                end
            end
            default: begin
                count_next = '0;
                clk_next   = 1'b0;
            end
        endcase
    end

    // mode is deliberately sampled through the reset path so the block powers up in the right mode.
    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            state_reg     <= bus.mode ? ST_IDLE : ST_RUN;
            count_reg     <= '0;
            div_act_reg   <= DIV_RST;
            clk_reg       <= 1'b0;
            clken_reg     <= 1'b0;
            clken_oop_reg <= 1'b0;
            cycle_cnt_reg <= '0;
            step_sync_reg <= '0;
        end else begin
            state_reg     <= state_next;
            count_reg     <= count_next;
            div_act_reg   <= div_act_next;
            clk_reg       <= clk_next;
            clken_reg     <= clken_next;
            clken_oop_reg <= clken_oop_next;
            cycle_cnt_reg <= cycle_cnt_next;
            step_sync_reg <= {step_sync_reg[1:0], bus.fp_step};
        end
    end

    assign bus.clk       = clk_reg;
    assign bus.clken     = clken_reg;
    assign bus.clken_oop = clken_oop_reg;
    assign bus.halted    = (state_reg == ST_HALTED);
    assign bus.cycle_cnt = cycle_cnt_reg;
endmodule

// File: tb/tb_sap_clken_gen.sv
// Bench for sap_clken_gen: directed scenarios with literal expectations, then random stimulus
// compared every cycle against an elapsed-time model of the slow clock.
module tb_sap_clken_gen;
    localparam int DIV_W       = 4;
    localparam int DIV_DEFAULT = 4;
    localparam int CYC_W       = 3;

    localparam int M_RUN  = 0;
    localparam int M_IDLE = 1;
    localparam int M_STEP = 2;
    localparam int M_HALT = 3;

    logic sysclk = 1'b0;
    logic reset  = 1'b1;

    sap_clken_gen_if #(.DIV_W(DIV_W), .CYC_W(CYC_W)) bus ();

    sap_clken_gen #(
        .DIV_W      (DIV_W),
        .DIV_DEFAULT(DIV_DEFAULT),
        .CYC_W      (CYC_W)
    ) dut (
        .sysclk(sysclk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 sysclk = ~sysclk;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 0;

    // Reference model: position within the current slow-clock cycle in elapsed sysclk edges.
    int m_st    = M_RUN;
    int m_k     = 0;
    int m_div   = DIV_DEFAULT;
    int m_cnt   = 0;
    int m_clk   = 0;
    int m_clken = 0;
    int m_oop   = 0;
    int fh[3]   = '{0, 0, 0};

    task automatic chk(input string name, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, got, exp);
        end
    endtask

    task automatic model_reset();
        m_st    = bus.mode ? M_IDLE : M_RUN;
        m_k     = 0;
        m_div   = (DIV_DEFAULT == 0) ? 1 : DIV_DEFAULT;
        m_cnt   = 0;
        m_clk   = 0;
        m_clken = 0;
        m_oop   = 0;
        fh      = '{0, 0, 0};
    endtask

    task automatic model_step();
        bit stepp;
        int dv;
        stepp   = (fh[1] == 1) && (fh[2] == 0);
        dv      = (bus.div == 0) ? 1 : int'(bus.div);
        m_clken = 0;
        m_oop   = 0;
        case (m_st)
            M_IDLE: begin
                m_clk = 0;
                m_k   = 0;
                m_div = dv;
                if (!bus.mode)  m_st = M_RUN;
                else if (stepp) m_st = M_STEP;
            end
            M_RUN, M_STEP: begin
                m_k++;
                if (m_k == m_div) begin
                    if (bus.halt) begin
                        m_st = M_HALT;
                        m_k  = 0;
                    end else begin
                        m_clk   = 1;
                        m_clken = 1;
                        m_cnt   = (m_cnt + 1) % (1 << CYC_W);
                    end
                end else if (m_k == 2 * m_div) begin
                    m_clk = 0;
                    m_oop = 1;
                    m_k   = 0;
                    if (m_st == M_STEP || bus.mode) m_st = M_IDLE;
                    m_div = dv;
                end
            end
            default: ;
        endcase
        fh[2] = fh[1];
        fh[1] = fh[0];
        fh[0] = int'(bus.fp_step);
    endtask

    initial begin
        forever begin
            @(posedge sysclk or posedge reset);
            if (reset) model_reset();
            else       model_step();
        end
    end

    initial begin
        forever begin
            @(negedge sysclk);
            if (chk_en) begin
                chk("cmp_clk",       int'(bus.clk),       m_clk);
                chk("cmp_clken",     int'(bus.clken),     m_clken);
                chk("cmp_clken_oop", int'(bus.clken_oop), m_oop);
                chk("cmp_halted",    int'(bus.halted),    (m_st == M_HALT) ? 1 : 0);
                chk("cmp_cycle_cnt", int'(bus.cycle_cnt), m_cnt);
                chk("cmp_overlap",   int'(bus.clken & bus.clken_oop), 0);
            end
        end
    end

    task automatic tick();
        @(posedge sysclk);
        #2;
    endtask

    // Leaves the bench 2 time units after the edge preceding edge 1.
    task automatic do_reset(input logic md, input int dv);
        reset       = 1'b1;
        bus.mode    = md;
        bus.div     = DIV_W'(dv);
        bus.halt    = 1'b0;
        bus.fp_step = 1'b0;
        #1;
        chk("rst_clken", int'(bus.clken), 0);
        repeat (2) tick();
        reset = 1'b0;
    endtask

    initial begin
        int first_ck, first_oop, n_ck, n_oop, n_hi;
        bus.div     = DIV_W'(DIV_DEFAULT);
        bus.mode    = 1'b0;
        bus.fp_step = 1'b0;
        bus.halt    = 1'b0;

        // Free run at the default divider
        do_reset(1'b0, 4);
        chk("reset_clk", int'(bus.clk), 0);
        chk("reset_cnt", int'(bus.cycle_cnt), 0);
        chk_en = 1;
        for (int e = 1; e <= 40; e++) begin
            tick();
            chk("fr_clken", int'(bus.clken), (e % 8 == 4) ? 1 : 0);
            chk("fr_oop", int'(bus.clken_oop), (e % 8 == 0) ? 1 : 0);
        end
        chk("fr_cnt", int'(bus.cycle_cnt), 5);

        // Divider change mid-cycle takes effect at the next full-cycle boundary
        do_reset(1'b0, 4);
        for (int e = 1; e <= 14; e++) begin
            tick();
            chk("div_clken", int'(bus.clken), (e == 4 || e == 10 || e == 14) ? 1 : 0);
            chk("div_oop", int'(bus.clken_oop), (e == 8 || e == 12) ? 1 : 0);
            if (e == 6) bus.div = DIV_W'(2);
        end

        // div = 0 behaves as 1: pulses alternate every edge
        do_reset(1'b1, 0);
        tick();
        tick();
        bus.mode = 1'b0;
        tick();
        for (int e = 1; e <= 6; e++) begin
            tick();
            chk("div0_clken", int'(bus.clken), e % 2);
            chk("div0_oop", int'(bus.clken_oop), 1 - (e % 2));
        end

        // Single step with div = 3
        do_reset(1'b1, 3);
        n_hi = 0;
        for (int e = 1; e <= 50; e++) begin
            tick();
            n_hi += int'(bus.clk) + int'(bus.clken) + int'(bus.clken_oop);
        end
        chk("step_idle_quiet", n_hi, 0);
        bus.fp_step = 1'b1;
        first_ck = -1; first_oop = -1; n_ck = 0; n_oop = 0;
        for (int e = 1; e <= 30; e++) begin
            tick();
            if (bus.clken)     begin n_ck++;  if (first_ck < 0)  first_ck = e;  end
            if (bus.clken_oop) begin n_oop++; if (first_oop < 0) first_oop = e; end
            if (e == 5) bus.fp_step = 1'b0;
            if (e == 6) bus.fp_step = 1'b1;
            if (e == 9) bus.fp_step = 1'b0;
        end
        chk("step_n_clken", n_ck, 1);
        chk("step_n_oop", n_oop, 1);
        chk("step_clken_edge", first_ck, 6);
        chk("step_oop_edge", first_oop, 9);
        chk("step_cnt", int'(bus.cycle_cnt), 1);

        // Halt raised while clk is high
        do_reset(1'b0, 4);
        n_ck = 0;
        for (int e = 1; e <= 30; e++) begin
            tick();
            if (e > 5 && bus.clken) n_ck++;
            if (e == 8)  chk("halt_oop", int'(bus.clken_oop), 1);
            if (e == 11) chk("halt_not_yet", int'(bus.halted), 0);
            if (e == 12) chk("halt_taken", int'(bus.halted), 1);
            if (e == 5) bus.halt = 1'b1;
        end
        chk("halt_no_clken", n_ck, 0);
        chk("halt_stays", int'(bus.halted), 1);
        chk("halt_cnt_frozen", int'(bus.cycle_cnt), 1);
        reset = 1'b1;
        #1;
        chk("halt_reset_clears", int'(bus.halted), 0);

        // Free run -> step mode mid-cycle -> back to free run
        do_reset(1'b0, 4);
        n_hi = 0;
        for (int e = 1; e <= 30; e++) begin
            tick();
            if (e == 8) chk("mode_oop", int'(bus.clken_oop), 1);
            if (e >= 9 && e <= 24) n_hi += int'(bus.clk) + int'(bus.clken) + int'(bus.clken_oop);
            if (e == 25) chk("mode_resume_clken", int'(bus.clken), 1);
            if (e == 5)  bus.mode = 1'b1;
            if (e == 20) bus.mode = 1'b0;
        end
        chk("mode_idle_quiet", n_hi, 0);

        // Reset during a clken pulse with cycle_cnt = 7, then wrap at the 8th clken
        do_reset(1'b0, 4);
        for (int e = 1; e <= 52; e++) tick();
        chk("rst7_clken", int'(bus.clken), 1);
        chk("rst7_cnt", int'(bus.cycle_cnt), 7);
        reset = 1'b1;
        #1;
        chk("rst_async_clken", int'(bus.clken), 0);
        chk("rst_async_clk", int'(bus.clk), 0);
        chk("rst_async_cnt", int'(bus.cycle_cnt), 0);
        tick();
        reset = 1'b0;
        for (int e = 1; e <= 60; e++) begin
            tick();
            if (e == 4)  chk("rst_first_clken", int'(bus.clken), 1);
            if (e == 52) chk("wrap_cnt7", int'(bus.cycle_cnt), 7);
            if (e == 60) chk("wrap_cnt0", int'(bus.cycle_cnt), 0);
        end

        // Randomised operation checked by the model
        do_reset(1'b0, 4);
        for (int i = 0; i < 3000; i++) begin
            tick();
            if ($urandom_range(0, 19) == 0)  bus.div     = DIV_W'($urandom_range(0, 5));
            if ($urandom_range(0, 39) == 0)  bus.mode    = ~bus.mode;
            if ($urandom_range(0, 5) == 0)   bus.fp_step = ~bus.fp_step;
            if ($urandom_range(0, 299) == 0) bus.halt    = 1'b1;
            if ($urandom_range(0, 399) == 0) begin
                bus.mode = 1'($urandom_range(0, 1));
                bus.halt = 1'b0;
                reset    = 1'b1;
                tick();
                reset = 1'b0;
            end
        end
        tick();
        chk_en = 0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
